four_func_arbiter: RTL

//  Shares one fourFuncEngine (series evaluator plus coefficient Table) among NUM_REQ requesters.

---
 rtl/four_func_arbiter_if.sv | 30 +++
 rtl/four_func_arbiter.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/four_func_arbiter_if.sv
// rtl/four_func_arbiter_if.sv - requester and engine signal bundle for the four_func_arbiter
interface four_func_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int F_WIDTH = 8
);
    logic [NUM_REQ-1:0]         req;
    logic [2*NUM_REQ-1:0]       func_bus;
    logic [F_WIDTH*NUM_REQ-1:0] x_bus;
    logic [NUM_REQ-1:0]         gnt;
    logic [NUM_REQ-1:0]         done;
    logic                       err;
    logic [1:0]                 result_i;
    logic [F_WIDTH-1:0]         result_f;
    logic                       eng_start;
    logic [1:0]                 eng_func;
    logic [F_WIDTH-1:0]         eng_x;
    logic                       eng_busy;
    logic [1:0]                 eng_result_i;
    logic [F_WIDTH-1:0]         eng_result_f;

    modport slave (
        input  req, func_bus, x_bus, eng_busy, eng_result_i, eng_result_f,
        output gnt, done, err, result_i, result_f, eng_start, eng_func, eng_x
    );

    modport master (
        output req, func_bus, x_bus, eng_busy, eng_result_i, eng_result_f,
        input  gnt, done, err, result_i, result_f, eng_start, eng_func, eng_x
    );
endinterface

// File: rtl/four_func_arbiter.sv
// rtl/four_func_arbiter.sv - round-robin sharing of one fourFunc engine among NUM_REQ requesters
module four_func_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2,
    parameter int F_WIDTH   = 8,
    parameter int ACK_LIMIT = 4,
    parameter int TIMEOUT   = 64,
    parameter int TO_WIDTH  = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    four_func_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_ACK,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state, w_state;
    logic [IDX_WIDTH-1:0] r_ptr, w_ptr;
    logic [TO_WIDTH-1:0]  r_cnt, w_cnt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt;
    logic [NUM_REQ-1:0]   r_done, w_done;
    logic                 r_err, w_err;
    logic [1:0]           r_res_i, w_res_i;
    logic [F_WIDTH-1:0]   r_res_f, w_res_f;
    logic                 r_start, w_start;
    logic [1:0]           r_func, w_func;
    logic [F_WIDTH-1:0]   r_x, w_x;

    logic [IDX_WIDTH-1:0] w_pick;
    logic                 w_any;

    // Search downward so the closest set bit after the pointer is the last one written.
    always_comb begin
        w_any  = |bus.req;
        w_pick = r_ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            int idx;
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (bus.req[idx]) begin
                w_pick = IDX_WIDTH'(idx);
            end
        end
    end

    always_comb begin
        w_state = r_state;
        w_ptr   = r_ptr;
        w_cnt   = r_cnt;
        w_gnt   = r_gnt;
        w_done  = '0;
        w_err   = 1'b0;
        w_res_i = r_res_i;
        w_res_f = r_res_f;
        w_start = 1'b0;
        w_func  = r_func;
        w_x     = r_x;

        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_gnt   = NUM_REQ'(1) << w_pick;
                    w_func  = bus.func_bus[2*int'(w_pick) +: 2];
                    w_x     = bus.x_bus[F_WIDTH*int'(w_pick) +: F_WIDTH];
                    w_ptr   = w_pick;
                    w_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_start = 1'b1;
                w_cnt   = '0;
                w_state = S_ACK;
            end
            S_ACK: begin
                if (bus.eng_busy) begin
                    w_cnt   = '0;
                    w_state = S_RUN;
                end else if (r_cnt == TO_WIDTH'(ACK_LIMIT - 1)) begin
                    w_done  = r_gnt;
                    w_err   = 1'b1;
                    w_res_i = '0;
                    w_res_f = '0;
                    w_state = S_DONE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_RUN: begin
                if (!bus.eng_busy) begin
                    w_done  = r_gnt;
                    w_res_i = bus.eng_result_i;
                    w_res_f = bus.eng_result_f;
                    w_state = S_DONE;
                end else if (r_cnt == TO_WIDTH'(TIMEOUT - 1)) begin
                    w_done  = r_gnt;
                    w_err   = 1'b1;
                    w_res_i = '0;
                    w_res_f = '0;
                    w_state = S_DONE;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            S_DONE: begin
                w_gnt   = '0;
                w_state = S_IDLE;
            end
            default: begin
                w_gnt   = '0;
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= IDX_WIDTH'(NUM_REQ - 1);
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_res_i <= '0;
            r_res_f <= '0;
            r_start <= 1'b0;
            r_func  <= '0;
            r_x     <= '0;
        end else begin
            r_state <= w_state;
            r_ptr   <= w_ptr;
            r_cnt   <= w_cnt;
            r_gnt   <= w_gnt;
            r_done  <= w_done;
            r_err   <= w_err;
            r_res_i <= w_res_i;
            r_res_f <= w_res_f;
            r_start <= w_start;
            r_func  <= w_func;
            r_x     <= w_x;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.result_i  = r_res_i;
    assign bus.result_f  = r_res_f;
    assign bus.eng_start = r_start;
    assign bus.eng_func  = r_func;
    assign bus.eng_x     = r_x;

endmodule
